// File: rtl/txeread.sv
// Transmit packet reader: fetches 32-bit words from the TX buffer RAM and
// streams them as nibbles (first byte at word MSB, low nibble first), one per i_ce.
module txeread #(
    parameter int unsigned AW = 12
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_start,
    input  logic [AW+1:0] i_len,
    input  logic          i_cancel,
    output logic [AW-1:0] o_raddr,
    input  logic [31:0]   i_rdata,
    output logic          o_busy,
    output logic          o_v,
    output logic [3:0]    o_d
);

    localparam int unsigned LW = AW + 2;
    localparam int unsigned NW = AW + 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_SEND = 3'd4,
        S_TAIL = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [NW-1:0] n_q, n_d;
    logic [31:0]   sreg_q, sreg_d;
    logic [31:0]   nxt_q, nxt_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          pend1_q, pend1_d;
    logic          pend2_q, pend2_d;
    logic          busy_q, busy_d;
    logic          v_q, v_d;
    logic [3:0]    d_q, d_d;

    logic          start_ok_c;
    logic [NW-1:0] last_n_c;
    logic          last_c;
    logic [3:0]    nib_c;

    assign start_ok_c = i_start && !busy_q && (i_len != '0);
    assign last_n_c   = {len_q, 1'b0} - NW'(1);
    assign last_c     = (n_q == last_n_c);

    // Byte order is big-endian within the word, nibble order is low-first within the byte.
    always_comb begin
        nib_c = sreg_q[27:24];
        case (n_q[2:0])
            3'd0: nib_c = sreg_q[27:24];
            3'd1: nib_c = sreg_q[31:28];
            3'd2: nib_c = sreg_q[19:16];
            3'd3: nib_c = sreg_q[23:20];
            3'd4: nib_c = sreg_q[11:8];
            3'd5: nib_c = sreg_q[15:12];
            3'd6: nib_c = sreg_q[3:0];
            3'd7: nib_c = sreg_q[7:4];
            default: nib_c = sreg_q[27:24];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_ok_c) state_d = S_P0;
                S_P0:   state_d = S_P1;
                S_P1:   state_d = S_P2;
                S_P2:   state_d = S_SEND;
                S_SEND: if (i_ce && last_c) state_d = S_TAIL;
                S_TAIL: if (i_ce) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values; the refill pipe lands i_rdata in nxt two clocks after the address bump.
    always_comb begin
        len_d   = len_q;
        n_d     = n_q;
        sreg_d  = sreg_q;
        nxt_d   = nxt_q;
        raddr_d = raddr_q;
        pend1_d = 1'b0;
        pend2_d = pend1_q;
        busy_d  = busy_q;
        v_d     = v_q;
        d_d     = d_q;

        if (pend2_q) begin
            nxt_d = i_rdata;
        end

        if (i_cancel) begin
            len_d   = '0;
            n_d     = '0;
            sreg_d  = '0;
            nxt_d   = '0;
            raddr_d = '0;
            pend2_d = 1'b0;
            busy_d  = 1'b0;
            v_d     = 1'b0;
            d_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok_c) begin
                        len_d   = i_len;
                        raddr_d = '0;
                        n_d     = '0;
                        busy_d  = 1'b1;
                    end
                end
                S_P0: raddr_d = AW'(1);
                S_P1: sreg_d  = i_rdata;
                S_P2: nxt_d   = i_rdata;
                S_SEND: begin
                    if (i_ce) begin
                        v_d = 1'b1;
                        d_d = nib_c;
                        n_d = n_q + NW'(1);
                        if (n_q[2:0] == 3'd7) begin
                            sreg_d  = nxt_q;
                            raddr_d = raddr_q + AW'(1);
                            pend1_d = 1'b1;
                        end
                    end
                end
                S_TAIL: begin
                    if (i_ce) begin
                        v_d    = 1'b0;
                        busy_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            len_q   <= '0;
            n_q     <= '0;
            sreg_q  <= '0;
            nxt_q   <= '0;
            raddr_q <= '0;
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
            busy_q  <= 1'b0;
            v_q     <= 1'b0;
            d_q     <= '0;
        end else begin
            len_q   <= len_d;
            n_q     <= n_d;
            sreg_q  <= sreg_d;
            nxt_q   <= nxt_d;
            raddr_q <= raddr_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            busy_q  <= busy_d;
            v_q     <= v_d;
            d_q     <= d_d;
        end
    end

    assign o_raddr = raddr_q;
    assign o_busy  = busy_q;
    assign o_v     = v_q;
    assign o_d     = d_q;

endmodule

// File: tb/tb_txeread.sv
// Scoreboard bench for txeread: a byte-level packet model queues expected nibbles,
// a monitor pops and compares every nibble the DUT emits.
module tb_txeread;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          reset, ce, start, cancel;
    logic [AW+1:0] len;
    logic [AW-1:0] raddr;
    logic [31:0]   rdata;
    logic          busy, v;
    logic [3:0]    d;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [3:0]    exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int emitted = 0;
    int ce_mode = 0;
    int ce_cnt  = 0;
    bit mon_ce;

    always #5 clk = ~clk;

    // Synchronous RAM: data in a cycle is the word addressed the cycle before.
    always @(posedge clk) rdata <= mem[raddr];

    txeread #(.AW(AW)) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_ce     (ce),
        .i_start  (start),
        .i_len    (len),
        .i_cancel (cancel),
        .o_raddr  (raddr),
        .i_rdata  (rdata),
        .o_busy   (busy),
        .o_v      (v),
        .o_d      (d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a nibble is emitted on every strobed edge that leaves o_v high.
    always begin
        @(posedge clk);
        mon_ce = ce;
        #1;
        if (mon_ce && v) begin
            emitted++;
            if (exp_q.size() == 0) begin
                check("unexpected_nibble", 32'(d), 32'hFFFF_FFFF);
            end else begin
                check("nibble", 32'(d), 32'(exp_q.pop_front()));
            end
        end
        if (v) check("v_implies_busy", 32'(busy), 32'd1);
    end

    // One clock step; inputs change at the falling edge.
    task automatic step();
        @(negedge clk);
        case (ce_mode)
            1: ce = 1'b1;
            2: ce = ((ce_cnt % 4) == 0);
            3: ce = ($urandom_range(0, 2) != 0);
            default: ce = 1'b0;
        endcase
        ce_cnt++;
    endtask

    task automatic push_model(input int L);
        for (int b = 0; b < L; b++) begin
            logic [31:0] w;
            logic [7:0]  by;
            w  = mem[b / 4];
            by = 8'(w >> (24 - 8 * (b % 4)));
            exp_q.push_back(by[3:0]);
            exp_q.push_back(by[7:4]);
        end
    endtask

    task automatic launch(input int L);
        push_model(L);
        len   = (AW+2)'(L);
        start = 1'b1;
        step();
        start = 1'b0;
        len   = (AW+2)'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finish_pkt(input int L, input int mode, input bit poke);
        int cyc, highs, rises, lat, bound;
        bit pv;
        logic [AW-1:0] exp_ra;
        cyc = 0; highs = 0; rises = 0; lat = -1; pv = 1'b0;
        bound = 16 * L + 200;
        while (busy && cyc < bound) begin
            if (poke && cyc == 6) begin
                start = 1'b1;
                len   = (AW+2)'($urandom_range(1, 100));
            end
            step();
            start = 1'b0;
            cyc++;
            if (v) begin
                highs++;
                if (!pv) begin
                    rises++;
                    if (lat < 0) lat = cyc;
                end
            end
            pv = v;
        end
        if (cyc >= bound) begin
            check("timeout", 32'd0, 32'd1);
            reset = 1'b1;
            step();
            reset = 1'b0;
            exp_q.delete();
        end
        check("v_low_when_idle", 32'(v), 32'd0);
        if (mode == 1) begin
            check("gapfree_highs", 32'(highs), 32'(2 * L));
            check("gapfree_rises", 32'(rises), 32'd1);
            check("first_nibble_latency", 32'(lat), 32'd4);
        end else if (mode == 2) begin
            check("slow_highs", 32'(highs), 32'(8 * L));
            check("slow_rises", 32'(rises), 32'd1);
        end
        check("leftover_nibbles", 32'(exp_q.size()), 32'd0);
        exp_ra = AW'(1 + L / 4);
        check("final_raddr", 32'(raddr), 32'(exp_ra));
    endtask

    task automatic run_pkt(input int L, input int mode, input bit poke);
        ce_mode = mode;
        launch(L);
        finish_pkt(L, mode, poke);
    endtask

    task automatic abort_after(input int nib, input bit use_reset);
        int base, k;
        base = emitted;
        ce_mode = 1;
        launch(8);
        k = 0;
        while (emitted < base + nib && k < 100) begin
            step();
            k++;
        end
        check("abort_reached", 32'(emitted - base), 32'(nib));
        ce_mode = 0;
        ce = 1'b0;
        if (use_reset) reset = 1'b1;
        else           cancel = 1'b1;
        step();
        reset  = 1'b0;
        cancel = 1'b0;
        check("abort_v", 32'(v), 32'd0);
        check("abort_d", 32'(d), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_raddr", 32'(raddr), 32'd0);
        check("abort_pending", 32'(exp_q.size()), 32'(16 - nib));
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; start = 1'b1; cancel = 1'b0; len = 5;
        for (int k = 0; k < (1 << AW); k++) mem[k] = $urandom;
        repeat (3) @(negedge clk);
        check("reset_v", 32'(v), 32'd0);
        check("reset_d", 32'(d), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_raddr", 32'(raddr), 32'd0);
        reset = 1'b0; start = 1'b0; ce = 1'b0;
        step();

        mem[0] = 32'h1234_5678;
        mem[1] = 32'h9ABC_DEF0;
        run_pkt(8, 1, 1'b0);
        run_pkt(5, 2, 1'b0);

        abort_after(8, 1'b0);
        run_pkt(4, 1, 1'b0);

        // Zero-length start and start colliding with cancel are both dropped.
        start = 1'b1; len = '0;
        step();
        start = 1'b0;
        step();
        check("zero_len_ignored", 32'(busy), 32'd0);
        start = 1'b1; len = 4; cancel = 1'b1;
        step();
        start = 1'b0; cancel = 1'b0;
        step();
        check("cancel_beats_start", 32'(busy), 32'd0);

        run_pkt(12, 1, 1'b1);
        abort_after(3, 1'b1);

        for (int k = 0; k < 64; k++) mem[k] = 32'(k) * 32'h0101_0101;
        run_pkt(256, 1, 1'b0);

        for (int k = 0; k < (1 << AW); k++) mem[k] = $urandom;
        run_pkt(16383, 1, 1'b0);

        for (int it = 0; it < 25; it++) begin
            int L, mode, gap;
            bit poke;
            L    = $urandom_range(1, 80);
            mode = $urandom_range(1, 3);
            poke = ($urandom_range(0, 1) == 1) && (L >= 4);
            gap  = $urandom_range(0, 3);
            for (int k = 0; k < 32; k++) mem[k] = $urandom;
            run_pkt(L, mode, poke);
            ce_mode = $urandom_range(0, 3);
            repeat (gap) step();
        end

        ce_mode = 0;
        repeat (4) step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/txeread.md
# txeread

Transmit-side packet reader for the Ethernet path. On a start command it reads a packet buffer of 32-bit words from a synchronous RAM and emits it as a nibble stream, one nibble per `i_ce`. The first byte of each word sits in the MSB, and within a byte the low nibble goes first. It sits between the CPU-filled TX buffer and the transmit filter chain (CRC/preamble/MII), mirroring the RX writer's word/nibble packing.

## Interface
- `AW`, 12: word-address width of the TX buffer; the buffer holds 4·2^AW bytes.
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_ce`  in  1  nibble strobe; at most one nibble is produced per asserted clock.
- `i_start`  in  1  start request; accepted only when `o_busy`=0 and `i_len`≠0.
- `i_len`  in  AW+2  packet length in bytes, latched on an accepted start.
- `i_cancel`  in  1  abort the packet in progress.
- `o_raddr`  out  AW  TX buffer read address.
- `i_rdata`  in  32  buffer data; in cycle t it equals mem[`o_raddr` of cycle t−1].
- `o_busy`  out  1  a packet is being fetched or sent.
- `o_v`  out  1  nibble valid.
- `o_d`  out  4  nibble data.

## Operation
- State machine states: IDLE, P0, P1, P2, SEND, TAIL.
- **IDLE**
  - On accepted start: latch `i_len`, set `o_raddr`←0, nibble counter n←0, `o_busy`←1, go to P0.
  - If `i_len`=0 or `o_busy`=1, `i_start` is ignored.
- **P0:** `o_raddr`←1, go to P1.
- **P1:** `sreg`←`i_rdata` (word 0), go to P2.
- **P2:** `nxt`←`i_rdata` (word 1), go to SEND.
  - `o_raddr` stays 1, the address of `nxt`.
- **SEND:** on each `i_ce`, `o_v`←1 and `o_d`←the nibble of `sreg` selected by n[2:0]:
  - 0→[27:24], 1→[31:28], 2→[19:16], 3→[23:20]
  - 4→[11:8], 5→[15:12], 6→[3:0], 7→[7:4]
  - Then n←n+1.
- **Word refill:** on an `i_ce` with n[2:0]=7, `sreg`←`nxt` and `o_raddr`←`o_raddr`+1.
  - A 2-stage pending flag captures `i_rdata` into `nxt` exactly two clocks later.
  - This guarantees `nxt` is valid before the next word boundary, even with `i_ce` every clock.
- **Last nibble:** on the `i_ce` that emits nibble n = 2·len−1, go to TAIL.
  - Nibble count is always even.
- **TAIL:** on the next `i_ce`, `o_v`←0, `o_busy`←0, go to IDLE.
- **Prefetch past the end:** reads beyond the last word are harmless. `o_raddr` wraps mod 2^AW and the data is discarded.
- **Partial last word:** only the bytes covered by len are sent; the trailing bytes of that word are never emitted.
- **`i_ce` outside SEND/TAIL:** ignored; `o_v` stays 0.
- **Arithmetic widths:** n is AW+3 bits; the last-nibble compare is {len,1'b0}−1, computed at full width.

## Timing
- **Reset values:** `o_v`=0, `o_d`=0, `o_busy`=0, `o_raddr`=0, state IDLE, n=0.
- **`i_reset` mid-packet:** returns to this state on the next clock, regardless of `i_ce`.
- **`i_cancel`:** identical effect to reset, on the next clock, regardless of `i_ce` or state.
  - `i_cancel` and `i_start` asserted together: cancel wins and the start is dropped.
- **Start latency:** start is sampled at edge t; SEND is entered at edge t+3.
  - The first nibble appears on the first `i_ce` edge at or after t+4.
- **Output timing:** `o_v`/`o_d` are registered and change only on `i_ce` edges, except for reset/cancel.
- **Gap-free stream:** with `i_ce` held high in SEND, `o_v` stays high for exactly 2·len consecutive clocks with no bubbles at word boundaries.
- **`o_busy`:** high from edge t+1 through the TAIL edge. A new start is accepted the clock after `o_busy` falls.

## Test plan
- **Two-word packet, continuous strobe.** mem[0]=0x12345678, mem[1]=0x9ABCDEF0, len=8, `i_ce`=1 continuously.
  - `o_d` = 2,1,4,3,6,5,8,7,A,9,C,B,E,D,0,F on 16 consecutive clocks.
  - `o_v` then drops and `o_busy` drops on the same edge.
- **Partial last word, slow strobe.** Same memory, len=5, `i_ce` every 4th clock.
  - Ten nibbles: 2,1,4,3,6,5,8,7,A,9, each held 4 clocks; then `o_v`=0.
- **Long packet, continuous strobe.** len=256, mem[k]=k·0x01010101, `i_ce`=1.
  - Every byte in word k equals k, sent low nibble first; `o_v` never drops between nibble 0 and nibble 511.
  - `o_raddr` ends at 65.
- **Cancel mid-packet.** `i_cancel` pulsed after nibble 7, with `i_ce` idle.
  - Next clock: `o_v`=0, `o_busy`=0.
  - A following start with len=4 sends 2,1,4,3,6,5,8,7 from word 0.
- **Ignored starts.** `i_start` with len=0 leaves `o_busy` 0. `i_start` while busy does not restart the packet or change its length.
- **Reset during SEND, strobe during prime.**
  - `i_reset` during SEND: all outputs 0 on the next clock.
  - `i_ce` during P0–P2 produces no `o_v`.
